// File: rtl/insn_pkg.sv
// ---------------------------------------------------------------------------
// insn_pkg -- definitions shared by the instruction encoder and its bench.
//
// Contents:
//   fmt_e               instruction format selector (R, I, JI, JII)
//   *_LSB               bit position of each field inside the 32-bit word
//   ALU_*               ALU operation codes carried in R-format words
//   OPC_RTYPE           the opcode that every R-format word must carry
// ---------------------------------------------------------------------------
package insn_pkg;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_JI  = 2'd2,
        FMT_JII = 2'd3
    } fmt_e;

    // Field placement inside the encoded word
    localparam int OP_LSB     = 27;  // [31:27]
    localparam int RD_LSB     = 22;  // [26:22]
    localparam int RS_LSB     = 17;  // [21:17]
    localparam int RT_LSB     = 12;  // [16:12]
    localparam int SHAMT_LSB  = 7;   // [11:7]
    localparam int ALUOP_LSB  = 2;   // [6:2]
    localparam int IMM_LSB    = 0;   // [16:0]
    localparam int TARGET_LSB = 0;   // [26:0]

    localparam int REG_W    = 5;
    localparam int IMM_W    = 17;
    localparam int TARGET_W = 27;
    localparam int INSN_W   = 32;

    // ALU operation codes
    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_SLL = 5'd4;
    localparam logic [4:0] ALU_SRA = 5'd5;
    localparam logic [4:0] ALU_MUL = 5'd6;
    localparam logic [4:0] ALU_DIV = 5'd7;

    localparam logic [4:0] OPC_RTYPE = 5'b00000;

endpackage

// File: rtl/insn_fifo.sv
// ---------------------------------------------------------------------------
// insn_fifo -- synchronous FIFO holding encoded instruction words.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   push_i, wdata_i      write a word (ignored while full)
//   pop_i                drop the head word (ignored while empty)
//   rdata_o              head word; reads zero while empty
//   full_o, empty_o      occupancy flags
//   count_o              number of stored words (0..DEPTH)
//
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// Reset clears the pointers and count asynchronously, which empties the
// FIFO at once; the storage array itself is not reset because rdata_o is
// forced to zero whenever the FIFO is empty.
// ---------------------------------------------------------------------------
module insn_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Simultaneous push and pop leaves the occupancy untouched
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/insn_encoder.sv
// ---------------------------------------------------------------------------
// insn_encoder -- packs instruction fields into 32-bit words and queues them.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   in_valid / in_ready          request handshake
//   in_fmt                       0 R, 1 I, 2 JI, 3 JII
//   in_op, in_aluop, in_rd, in_rs, in_rt, in_shamt, in_imm, in_target
//                                raw instruction fields
//   out_valid / out_ready        output handshake
//   out_insn                     head word (zero while out_valid is low)
//   count                        FIFO occupancy
//   err_illegal                  one-cycle pulse after a rejected request
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on occupancy (never on out_ready), and
// out_valid/out_insn stay stable until the consumer raises out_ready.
//
// Optional checking: define INSN_ENC_CHECK_EN to reject R-format requests
// whose opcode is not the R-type opcode or whose ALU op is above DIV. A
// rejected request still completes its handshake but is not queued. With the
// macro undefined every request is queued and err_illegal is held at zero.
// ---------------------------------------------------------------------------
module insn_encoder
    import insn_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_fmt,
    input  logic [4:0]               in_op,
    input  logic [4:0]               in_aluop,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_rs,
    input  logic [4:0]               in_rt,
    input  logic [4:0]               in_shamt,
    input  logic [16:0]              in_imm,
    input  logic [26:0]              in_target,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_insn,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_illegal
);

    logic [INSN_W-1:0] word;
    logic              accept;
    logic              illegal;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;

    // Field packing; fields the selected format does not use never reach
    // the word because it starts from zero and only the used slices are set.
    always_comb begin
        word = '0;
        word[OP_LSB +: REG_W] = in_op;
        case (fmt_e'(in_fmt))
            FMT_R: begin
                word[RD_LSB    +: REG_W] = in_rd;
                word[RS_LSB    +: REG_W] = in_rs;
                word[RT_LSB    +: REG_W] = in_rt;
                word[SHAMT_LSB +: REG_W] = in_shamt;
                word[ALUOP_LSB +: REG_W] = in_aluop;
            end
            FMT_I: begin
                word[RD_LSB  +: REG_W] = in_rd;
                word[RS_LSB  +: REG_W] = in_rs;
                word[IMM_LSB +: IMM_W] = in_imm;
            end
            FMT_JI: begin
                word[TARGET_LSB +: TARGET_W] = in_target;
            end
            FMT_JII: begin
                word[RD_LSB +: REG_W] = in_rd;
            end
            default: begin
                word = '0;
            end
        endcase
    end

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign push      = accept && !illegal;

`ifdef INSN_ENC_CHECK_EN
    logic err_q, err_d;

    assign illegal = (fmt_e'(in_fmt) == FMT_R) &&
                     ((in_op != OPC_RTYPE) || (in_aluop > ALU_DIV));
    assign err_d   = accept && illegal;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_illegal = err_q;
`else
    assign illegal     = 1'b0;
    assign err_illegal = 1'b0;
`endif

    insn_fifo #(
        .WIDTH (INSN_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (word),
        .pop_i   (pop),
        .rdata_o (out_insn),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

endmodule

// File: doc/insn_encoder.md
INSN_ENCODER -- requirements
Module: insn_encoder

Interface
REQ-001 Parameter DEPTH, default 4, instruction FIFO entries; power of two, 2..16.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  encoder accepts the request this cycle.
REQ-006 in_fmt  input  2  format: 0 R, 1 I, 2 JI, 3 JII.
REQ-007 in_op  input  5  opcode; in_aluop  input  5  ALU op (R only).
REQ-008 in_rd, in_rs, in_rt, in_shamt  input  5 each  register and shift fields.
REQ-009 in_imm  input  17  immediate (I); in_target  input  27  jump target (JI).
REQ-010 out_valid  output  1  out_insn holds a valid word.
REQ-011 out_ready  input  1  consumer takes out_insn this cycle.
REQ-012 out_insn  output  32  encoded instruction.
REQ-013 count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-014 err_illegal  output  1  one-cycle pulse on a rejected request.

Function
REQ-015 R word SHALL be op[31:27], rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2], 2'b00[1:0].
REQ-016 I word SHALL be op[31:27], rd[26:22], rs[21:17], imm[16:0].
REQ-017 JI word SHALL be op[31:27], target[26:0]; JII word SHALL be op[31:27], rd[26:22], zeros[21:0].
REQ-018 Fields not used by the selected format SHALL be ignored and SHALL NOT affect out_insn.
REQ-019 Accept handshake: in_valid && in_ready; in_ready SHALL equal (count != DEPTH), with no dependence on out_ready.
REQ-020 Output handshake: out_valid && out_ready pops the head; out_valid SHALL equal (count != 0).
REQ-021 Latency: a request accepted in cycle N into an empty FIFO SHALL appear on out_insn with out_valid in cycle N+1.
REQ-022 Words SHALL leave in strict acceptance order.
REQ-023 out_insn and out_valid SHALL hold steady while out_valid && !out_ready.
REQ-024 Push and pop in the same cycle SHALL leave count unchanged; this includes the full case only when the pop occurs and in_ready was already high.
REQ-025 Pop when empty and push when full SHALL be impossible via the handshake; pointers SHALL wrap modulo DEPTH.
REQ-026 out_insn SHALL read 32'h0 when out_valid is low.

Reset
REQ-027 While reset is high: count=0, pointers=0, out_valid=0, out_insn=0, err_illegal=0, in_ready=1.
REQ-028 Reset asserted mid-operation SHALL discard all queued words immediately, without waiting for a clock edge.

Configuration
REQ-029 With macro INSN_ENC_CHECK_EN defined, a request SHALL be rejected when R format has op != 5'b00000, or when aluop > 5'b00111.
REQ-030 A rejected request SHALL be consumed (handshake completes) but not queued, and SHALL pulse err_illegal high for exactly the following cycle.
REQ-031 Without INSN_ENC_CHECK_EN, every request SHALL be queued, and err_illegal SHALL be tied to 0.

Structure
REQ-032 Shared package insn_pkg SHALL hold the format enum, the field bit-position constants, the ALU op codes (ADD=0, SUB=1, AND=2, OR=3, SLL=4, SRA=5, MUL=6, DIV=7) and the R-type opcode 5'b00000.
REQ-033 Storage SHALL be the sub-module insn_fifo (width 32, depth DEPTH); the field packing SHALL stay combinational in insn_encoder.

Verification
REQ-034 R AND: fmt=0, op=0, rd=3, rs=1, rt=2, shamt=0, aluop=2 -> next cycle out_insn=32'h00C22008, out_valid=1.
REQ-035 I addi: fmt=1, op=5'b00101, rd=4, rs=0, imm=17'h1FFFF -> out_insn=32'h2901FFFF.
REQ-036 Backpressure: hold out_ready=0, push DEPTH words -> in_ready=0, count=DEPTH; raise out_ready -> words drain in order, in_ready returns to 1 the cycle after the first pop.
REQ-037 Simultaneous push and pop at count=2 -> count stays 2, and order is preserved.
REQ-038 With INSN_ENC_CHECK_EN defined: R request with aluop=5'b01000 -> err_illegal=1 for one cycle and count unchanged; without the macro -> the word is queued and err_illegal stays 0.
REQ-039 Assert reset with 3 words queued -> count=0 and out_valid=0 immediately; after release, the first push appears one cycle later.
